// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two requesters
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   reqN_valid_i / reqN_ready_o         operand handshake for requester N (0/1)
//   reqN_a_i, reqN_b_i, reqN_op_i       requester N operands and operation code
//   alu_a_o, alu_b_o, alu_op_o          operands driven to the external ALU
//   alu_result_i                        combinational ALU result
//   rsp_valid_o / rsp_ready_i           response handshake
//   rsp_id_o, rsp_result_o              issuing requester and registered result
//   rsp_zero_o, rsp_err_o               result-is-zero and illegal-opcode flags
module alu_arbiter #(
  parameter int SIZEDATA = 32,
  parameter int OP       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic [SIZEDATA-1:0] req0_a_i,
  input  logic [SIZEDATA-1:0] req0_b_i,
  input  logic [OP-1:0]       req0_op_i,
  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic [SIZEDATA-1:0] req1_a_i,
  input  logic [SIZEDATA-1:0] req1_b_i,
  input  logic [OP-1:0]       req1_op_i,
  output logic [SIZEDATA-1:0] alu_a_o,
  output logic [SIZEDATA-1:0] alu_b_o,
  output logic [OP-1:0]       alu_op_o,
  input  logic [SIZEDATA-1:0] alu_result_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_id_o,
  output logic [SIZEDATA-1:0] rsp_result_o,
  output logic                rsp_zero_o,
  output logic                rsp_err_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t              state_q, state_d;
  logic [SIZEDATA-1:0] a_q, b_q, res_q, res_d;
  logic [OP-1:0]       op_q;
  logic                id_q, last_q, rid_q, zero_q, err_q;
  logic                gnt0, gnt1, legal;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (gnt0 || gnt1) ? EXEC : IDLE;
      EXEC:    state_d = RESP;
      RESP:    state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // On a tie the requester not served last wins; readys are masked during reset
  always_comb begin
    gnt0         = rst_n && state_q == IDLE && req0_valid_i && (!req1_valid_i || last_q);
    gnt1         = rst_n && state_q == IDLE && req1_valid_i && (!req0_valid_i || !last_q);
    req0_ready_o = gnt0;
    req1_ready_o = gnt1;
    rsp_valid_o  = state_q == RESP;
  end
  always_comb begin
    legal = op_q == OP'(4'b0000) || op_q == OP'(4'b0001) || op_q == OP'(4'b0010) ||
            op_q == OP'(4'b0110) || op_q == OP'(4'b0111) || op_q == OP'(4'b1100);
    res_d = legal ? alu_result_i : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
      res_q  <= '0;
      rid_q  <= 1'b0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (gnt0 || gnt1) begin
      a_q  <= gnt1 ? req1_a_i  : req0_a_i;
      b_q  <= gnt1 ? req1_b_i  : req0_b_i;
      op_q <= gnt1 ? req1_op_i : req0_op_i;
      id_q <= gnt1;
    end else if (state_q == EXEC) begin
      res_q  <= res_d;
      rid_q  <= id_q;
      zero_q <= res_d == '0;
      err_q  <= !legal;
      last_q <= id_q;
    end
  always_comb begin
    alu_a_o      = a_q;
    alu_b_o      = b_q;
    alu_op_o     = op_q;
    rsp_id_o     = rid_q;
    rsp_result_o = res_q;
    rsp_zero_o   = zero_q;
    rsp_err_o    = err_q;
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        req0_valid = 0, req1_valid = 0, rsp_ready = 1;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_err;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0]  req0_op = 0, req1_op = 0, alu_op;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  alu_arbiter #(.SIZEDATA(32), .OP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
    .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_op_i(req0_op),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
    .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_op_i(req1_op),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_result_i(alu_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err)
  );
  // ALU stand-in; illegal codes deliberately yield a nonzero value
  always_comb
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = {31'd0, alu_a < alu_b};
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rsp_chk(input string tag, input logic id, input logic [31:0] res,
                         input logic zero, input logic err);
    chk({tag, ".valid"}, rsp_valid, 1);
    chk({tag, ".id"}, rsp_id, id);
    chk({tag, ".res"}, rsp_result, res);
    chk({tag, ".zero"}, rsp_zero, zero);
    chk({tag, ".err"}, rsp_err, err);
  endtask
  task automatic run_one(input string tag, input logic which, input logic [31:0] a, b,
                         input logic [3:0] op, input logic [31:0] res,
                         input logic zero, input logic err);
    if (which) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    chk({tag, ".rdy"}, {req1_ready, req0_ready}, which ? 2 : 1);
    tick;
    req0_valid = 0; req1_valid = 0;
    #1;
    chk({tag, ".exec_valid"}, rsp_valid, 0);
    chk({tag, ".alu_a"}, alu_a, a);
    chk({tag, ".alu_op"}, alu_op, op);
    tick;
    rsp_chk(tag, which, res, zero, err);
    tick;
    chk({tag, ".drop"}, rsp_valid, 0);
  endtask
  initial begin
    #2;
    req0_valid = 1;
    #1;
    chk("rst.rdy0", req0_ready, 0);
    req0_valid = 0;
    chk("rst.valid", rsp_valid, 0);
    chk("rst.res", rsp_result, 0);
    chk("rst.alu", {alu_a, alu_b, alu_op}, 0);
    #10 rst_n = 1;
    tick; tick; tick;
    chk("idle.rdy", {req1_ready, req0_ready}, 0);
    chk("idle.valid", rsp_valid, 0);
    chk("idle.flags", {rsp_id, rsp_zero, rsp_err}, 0);
    chk("idle.alu", {alu_a, alu_b, alu_op}, 0);
    // round robin with both requesters always valid
    req0_valid = 1; req0_a = 9; req0_b = 9; req0_op = 4'b0110;
    req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr.rdy", {req1_ready, req0_ready}, i[0] ? 2 : 1);
      tick;
      chk("rr.exec_rdy", {req1_ready, req0_ready}, 0);
      tick;
      if (i[0]) rsp_chk("rr1", 1, 32'hFF, 0, 0);
      else      rsp_chk("rr0", 0, 0, 1, 0);
      tick;
    end
    req0_valid = 0; req1_valid = 0;
    #1;
    run_one("add", 0, 5, 7, 4'b0010, 12, 0, 0);
    run_one("addwrap", 0, 32'hFFFF_FFFF, 1, 4'b0010, 0, 1, 0);
    run_one("slt", 1, 3, 5, 4'b0111, 1, 0, 0);
    run_one("sltu", 0, 32'hFFFF_FFFF, 1, 4'b0111, 0, 1, 0);
    run_one("nor", 1, 0, 0, 4'b1100, 32'hFFFF_FFFF, 0, 0);
    run_one("sub", 0, 3, 5, 4'b0110, 32'hFFFF_FFFE, 0, 0);
    run_one("ill", 1, 3, 5, 4'b0011, 0, 1, 1);
    // backpressure: last grant was req1, so req0 wins the tie
    rsp_ready = 0;
    req0_valid = 1; req0_a = 32'hF0F0; req0_b = 32'hFF00; req0_op = 4'b0000;
    req1_valid = 1; req1_a = 3; req1_b = 5; req1_op = 4'b0111;
    #1;
    chk("bp.rdy", {req1_ready, req0_ready}, 1);
    tick;
    req0_valid = 0;
    tick;
    for (int i = 0; i < 5; i++) begin
      rsp_chk("bp.hold", 0, 32'hF000, 0, 0);
      chk("bp.rdy_hold", {req1_ready, req0_ready}, 0);
      tick;
    end
    rsp_ready = 1;
    #1;
    rsp_chk("bp.rel", 0, 32'hF000, 0, 0);
    tick;
    chk("bp.idle_valid", rsp_valid, 0);
    chk("bp.req1_gnt", {req1_ready, req0_ready}, 2);
    tick;
    req1_valid = 0;
    tick;
    rsp_chk("bp.req1", 1, 1, 0, 0);
    tick;
    // reset during EXEC of a req1 operation
    req1_valid = 1; req1_a = 1; req1_b = 2; req1_op = 4'b0010;
    tick;
    req1_valid = 0;
    chk("mid.alu_a", alu_a, 1);
    rst_n = 0;
    #1;
    chk("mid.valid", rsp_valid, 0);
    chk("mid.alu", {alu_a, alu_b, alu_op}, 0);
    chk("mid.res", rsp_result, 0);
    tick; tick;
    chk("mid.valid2", rsp_valid, 0);
    rst_n = 1;
    tick;
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 4'b0010;
    req1_valid = 1;
    #1;
    chk("post.tie", {req1_ready, req0_ready}, 1);
    tick;
    req0_valid = 0; req1_valid = 0;
    tick;
    rsp_chk("post", 0, 12, 0, 0);
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
